// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-to-4 decoded resource.
// Latency: request seen at edge N gives a registered grant after edge N.
// Backpressure: a grant is held until done, request drop or the HOLD_MAX watchdog fires.
module rr_decoder_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_en,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       rel_done;
  logic       rel_req;
  logic       rel_age;

  // Rotating priority search: first requester at or after ptr wins.
  // Loop runs from lowest priority to highest so the highest priority hit overwrites.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    cand    = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Release causes for the current owner; only the owner's bits matter.
  always_comb begin
    rel_done = done[grant_idx];
    rel_req  = ~req[grant_idx];
    rel_age  = (hold_cnt == CNT_W'(HOLD_MAX - 1));
  end

  // Arbitration FSM with registered decoder-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 4'b0000;
      grant_idx <= 2'b00;
      grant_en  <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= 2'b00;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (win_vld) begin
            grant_idx <= win_idx;
            grant     <= 4'b0001 << win_idx;
            grant_en  <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (rel_done || rel_req || rel_age) begin
            // Release always passes through IDLE: break-before-make on the decoder.
            grant    <= 4'b0000;
            grant_en <= 1'b0;
            ptr      <= grant_idx + 2'd1;
            timeout  <= ~rel_done & ~rel_req;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
            timeout  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= 4'b0000;
          grant_en <= 1'b0;
          timeout  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = grant_en;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter with a cycle-level reference model.
// Model and DUT both advance on the rising edge; outputs are compared on the falling edge.
// Inputs change 2 time units after each rising edge.
module tb_rr_decoder_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_en;
  logic       timeout;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  bit started = 1'b0;

  rr_decoder_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .grant_en(grant_en),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: who owns the resource, for how many cycles, and where priority starts.
  int owner  = -1;
  int last   = 0;
  int age    = 0;
  int prio   = 0;
  bit m_to   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      owner = -1; last = 0; age = 0; prio = 0; m_to = 1'b0;
    end else if (owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (owner < 0 && req[(prio + k) % 4]) begin
          owner = (prio + k) % 4;
          last  = owner;
          age   = 0;
        end
      end
    end else begin
      bit by_done, by_drop, by_age;
      by_done = done[owner];
      by_drop = !req[owner];
      by_age  = (age + 1 >= HOLD);
      if (by_done || by_drop || by_age) begin
        m_to  = !by_done && !by_drop;
        prio  = (owner + 1) % 4;
        owner = -1;
      end else begin
        age  = age + 1;
        m_to = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("model_grant", int'(grant), (owner >= 0) ? (1 << owner) : 0);
      chk("model_idx", int'(grant_idx), last);
      chk("model_en", int'(grant_en), (owner >= 0) ? 1 : 0);
      chk("model_busy", int'(busy), (owner >= 0) ? 1 : 0);
      chk("model_timeout", int'(timeout), int'(m_to));
    end
  end

  // Apply inputs, then let one rising edge pass; returns 2 units after that edge.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; done = 4'b0000;
    @(posedge clk); #2;
    step(4'b0000, 4'b0000, 1'b1);
    started = 1'b1;

    // Idle: nothing requested for five cycles.
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b0000, 1'b0);
      chk("idle_outputs", int'({grant, grant_idx, grant_en, timeout}), 0);
    end

    // Rotation with done one cycle after each grant.
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 4'b0000, 1'b0);
      chk("rot_grant", int'(grant), 1 << i);
      chk("rot_idx", int'(grant_idx), i);
      step(4'b1111, 4'b0001 << i, 1'b0);
      chk("rot_gap", int'({grant, grant_en, timeout}), 0);
    end
    step(4'b1111, 4'b0000, 1'b0);
    chk("rot_wrap_grant", int'(grant), 4'b0001);
    chk("rot_wrap_idx", int'(grant_idx), 0);
    step(4'b1111, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Watchdog: requester 0 holds with no done; grant lasts exactly HOLD cycles.
    step(4'b0001, 4'b0000, 1'b0);
    chk("to_grant", int'(grant), 4'b0001);
    for (int i = 1; i < HOLD; i++) begin
      step(4'b0001, 4'b0000, 1'b0);
      chk("to_held", int'({grant_en, timeout}), 2'b10);
    end
    step(4'b0001, 4'b0000, 1'b0);
    chk("to_release", int'({grant_en, timeout}), 2'b01);
    step(4'b0001, 4'b0000, 1'b0);
    chk("to_regrant", int'({grant, timeout}), 5'b0001_0);
    step(4'b0000, 4'b0000, 1'b0);
    chk("to_drop_release", int'({grant_en, timeout}), 0);
    step(4'b0000, 4'b0000, 1'b0);

    // Pointer wrap: owner 3 releases by dropping req while requester 2 waits.
    step(4'b1000, 4'b0000, 1'b0);
    chk("wrap_grant3", int'(grant), 4'b1000);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b0);
    chk("wrap_release", int'({grant_en, timeout}), 0);
    step(4'b0100, 4'b0000, 1'b0);
    chk("wrap_grant2", int'(grant), 4'b0100);
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Request drop: requester 1 granted (priority starts at 3), drops while 2 waits.
    step(4'b0010, 4'b0000, 1'b0);
    chk("drop_grant1", int'(grant), 4'b0010);
    step(4'b0100, 4'b0000, 1'b0);
    chk("drop_release", int'({grant_en, timeout}), 0);
    step(4'b0100, 4'b0000, 1'b0);
    chk("drop_grant2", int'(grant), 4'b0100);

    // Reset while requester 2 holds the resource.
    step(4'b1111, 4'b0000, 1'b1);
    chk("rst_mid_grant", int'({grant, grant_en, timeout}), 0);
    step(4'b1111, 4'b0000, 1'b0);
    chk("rst_first_grant", int'(grant), 4'b0001);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
